// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM with clear sequencer.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Number of bytes in a DW-bit word
  function automatic int unsigned nbytes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Even-parity bit for one byte: makes the total count of ones even
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address once, writing INIT, and reports busy.
// Starts after reset (optional) or on a clr pulse; clr while clearing restarts.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AW           = 10,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);

  clr_state_t    state;
  logic [AW-1:0] cnt;
  logic          start_pend;

  // FSM, address counter and registered busy flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      start_pend <= (CLR_ON_RESET != 0);
    end else begin
      case (state)
        IDLE: begin
          start_pend <= 1'b0;
          if (clr || start_pend) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (&cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only,
// 1- or 2-cycle read latency (OREG), built-in clear-to-INIT sequencer.
// Optional macro RAM_PARITY_EN adds one even-parity bit per stored byte
// and drives a_perr/b_perr; without it both are tied low.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int            DW           = 8,
  parameter int            AW           = 10,
  parameter int            OREG         = 0,
  parameter logic [DW-1:0] INIT         = '0,
  parameter int            CLR_ON_RESET = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            a_ce,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [AW-1:0]   a_a,
  input  logic [DW-1:0]   a_d,
  output logic [DW-1:0]   a_q,
  input  logic            b_ce,
  input  logic [AW-1:0]   b_a,
  output logic [DW-1:0]   b_q,
  input  logic            clr,
  output logic            busy,
  output logic            a_perr,
  output logic            b_perr
);

  localparam int NB    = nbytes(DW);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clr_seq #(
    .AW          (AW),
    .CLR_ON_RESET(CLR_ON_RESET)
  ) u_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  // Port requests are ignored entirely while the sequencer owns the array
  logic a_rd_p0, a_wr_p0, b_rd_p0;
  logic a_perr_p0, b_perr_p0;

  assign a_rd_p0 = a_ce & ~a_we & ~busy;
  assign a_wr_p0 = a_ce &  a_we & ~busy;
  assign b_rd_p0 = b_ce & ~busy;

  // Array write: clear data while busy, otherwise byte-masked port A data
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT;
    end else if (a_wr_p0) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) mem[a_a][8*i +: 8] <= a_d[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  function automatic logic [NB-1:0] word_par(input logic [DW-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i] = par8(w[8*i +: 8]);
    return p;
  endfunction

  // Parity store tracks every array write, including INIT fills
  always_ff @(posedge clock) begin
    if (clr_we) begin
      par[clr_addr] <= word_par(INIT);
    end else if (a_wr_p0) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) par[a_a][i] <= par8(a_d[8*i +: 8]);
      end
    end
  end

  assign a_perr_p0 = |(par[a_a] ^ word_par(mem[a_a]));
  assign b_perr_p0 = |(par[b_a] ^ word_par(mem[b_a]));
`else
  assign a_perr_p0 = 1'b0;
  assign b_perr_p0 = 1'b0;
`endif

  // ---- stage 1: registered array read (read-first against port A writes)
  logic [DW-1:0] a_q_p1, b_q_p1;
  logic          a_perr_p1, b_perr_p1;

  // Port A read register; holds when no read is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q_p1    <= '0;
      a_perr_p1 <= 1'b0;
    end else if (a_rd_p0) begin
      a_q_p1    <= mem[a_a];
      a_perr_p1 <= a_perr_p0;
    end
  end

  // Port B read register; holds when no read is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_q_p1    <= '0;
      b_perr_p1 <= 1'b0;
    end else if (b_rd_p0) begin
      b_q_p1    <= mem[b_a];
      b_perr_p1 <= b_perr_p0;
    end
  end

  // ---- stage 2: optional output register, advances only behind a real read
  generate
    if (OREG != 0) begin : g_oreg
      logic          a_vld_p1, b_vld_p1;
      logic [DW-1:0] a_q_p2, b_q_p2;
      logic          a_perr_p2, b_perr_p2;

      // Valid flags tag which stage-1 contents are fresh reads
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_vld_p1 <= 1'b0;
          b_vld_p1 <= 1'b0;
        end else begin
          a_vld_p1 <= a_rd_p0;
          b_vld_p1 <= b_rd_p0;
        end
      end

      // Output registers load only from a fresh stage-1 read
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_q_p2    <= '0;
          a_perr_p2 <= 1'b0;
          b_q_p2    <= '0;
          b_perr_p2 <= 1'b0;
        end else begin
          if (a_vld_p1) begin
            a_q_p2    <= a_q_p1;
            a_perr_p2 <= a_perr_p1;
          end
          if (b_vld_p1) begin
            b_q_p2    <= b_q_p1;
            b_perr_p2 <= b_perr_p1;
          end
        end
      end

      assign a_q    = a_q_p2;
      assign a_perr = a_perr_p2;
      assign b_q    = b_q_p2;
      assign b_perr = b_perr_p2;
    end else begin : g_noreg
      assign a_q    = a_q_p1;
      assign a_perr = a_perr_p1;
      assign b_q    = b_q_p1;
      assign b_perr = b_perr_p1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances (OREG=0 and OREG=1, DW=16, AW=4,
// INIT=A5A5) share one stimulus stream and are compared every cycle with a
// behavioural memory model; directed sections pin the model with literals.
module tb_ram_dp_clr;

  localparam int          DW    = 16;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] INITV = 16'hA5A5;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_ce    = 1'b0;
  logic        a_we    = 1'b0;
  logic [1:0]  a_be    = 2'b00;
  logic [3:0]  a_a     = 4'd0;
  logic [15:0] a_d     = 16'd0;
  logic        b_ce    = 1'b0;
  logic [3:0]  b_a     = 4'd0;
  logic        clr     = 1'b0;

  logic [15:0] u0_a_q, u0_b_q, u1_a_q, u1_b_q;
  logic        u0_busy, u1_busy, u0_a_perr, u0_b_perr, u1_a_perr, u1_b_perr;

  ram_dp_clr #(.DW(DW), .AW(AW), .OREG(0), .INIT(INITV), .CLR_ON_RESET(1)) u0 (
    .clock(clock), .reset_n(reset_n),
    .a_ce(a_ce), .a_we(a_we), .a_be(a_be), .a_a(a_a), .a_d(a_d), .a_q(u0_a_q),
    .b_ce(b_ce), .b_a(b_a), .b_q(u0_b_q),
    .clr(clr), .busy(u0_busy), .a_perr(u0_a_perr), .b_perr(u0_b_perr)
  );

  ram_dp_clr #(.DW(DW), .AW(AW), .OREG(1), .INIT(INITV), .CLR_ON_RESET(1)) u1 (
    .clock(clock), .reset_n(reset_n),
    .a_ce(a_ce), .a_we(a_we), .a_be(a_be), .a_a(a_a), .a_d(a_d), .a_q(u1_a_q),
    .b_ce(b_ce), .b_a(b_a), .b_q(u1_b_q),
    .clr(clr), .busy(u1_busy), .a_perr(u1_a_perr), .b_perr(u1_b_perr)
  );

  always #5 clock = ~clock;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mem_m [DEPTH];
  logic [1:0]  corr  [DEPTH];   // bytes whose stored parity was corrupted
  int          left;            // clear writes still to do
  bit          busy_m;
  bit          pend;            // automatic clear due after reset
  logic [16:0] qa1, qb1, qa2, qb2, pa_d, pb_d;  // {perr, data}
  bit          pa_v, pb_v;

`ifdef RAM_PARITY_EN
  int          flip_cnt  = 0;
  int          flip_seen = 0;
  logic [3:0]  flip_addr = 4'd0;
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 16'h0;
      corr[i]  = 2'b00;
    end
  end

  always @(posedge clock) begin
    logic [16:0] ra, rb;
    bit          va, vb;
    int          idx;
`ifdef RAM_PARITY_EN
    if (flip_cnt != flip_seen) begin
      mem_m[flip_addr]    = mem_m[flip_addr] ^ 16'h0001;
      corr[flip_addr][0]  = ~corr[flip_addr][0];
      flip_seen           = flip_cnt;
    end
`endif
    if (!reset_n) begin
      left = 0; busy_m = 0; pend = 1;
      qa1 = '0; qb1 = '0; qa2 = '0; qb2 = '0;
      pa_v = 0; pb_v = 0; pa_d = '0; pb_d = '0;
    end else begin
      va = 0; vb = 0; ra = '0; rb = '0;
      if (!busy_m) begin
        va = a_ce && !a_we;
        vb = b_ce;
        if (va) ra = {|corr[a_a], mem_m[a_a]};
        if (vb) rb = {|corr[b_a], mem_m[b_a]};
        if (a_ce && a_we) begin
          for (int i = 0; i < 2; i++) begin
            if (a_be[i]) begin
              mem_m[a_a][8*i +: 8] = a_d[8*i +: 8];
              corr[a_a][i]         = 1'b0;
            end
          end
        end
        if (pend || clr) begin
          left   = DEPTH;
          busy_m = 1;
        end
        pend = 0;
      end else begin
        idx        = DEPTH - left;
        mem_m[idx] = INITV;
        corr[idx]  = 2'b00;
        left       = clr ? DEPTH : left - 1;
        busy_m     = (left != 0);
      end
      // two-edge view: the read accepted one edge ago surfaces now
      if (pa_v) qa2 = pa_d;
      if (pb_v) qb2 = pb_d;
      pa_v = va; pa_d = ra;
      pb_v = vb; pb_d = rb;
      if (va) qa1 = ra;
      if (vb) qb1 = rb;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(posedge clock) begin
    #2;
    check("u0_busy",   u0_busy,   busy_m);
    check("u1_busy",   u1_busy,   busy_m);
    check("u0_a_q",    u0_a_q,    qa1[15:0]);
    check("u0_b_q",    u0_b_q,    qb1[15:0]);
    check("u1_a_q",    u1_a_q,    qa2[15:0]);
    check("u1_b_q",    u1_b_q,    qb2[15:0]);
    check("u0_a_perr", u0_a_perr, qa1[16]);
    check("u0_b_perr", u0_b_perr, qb1[16]);
    check("u1_a_perr", u1_a_perr, qa2[16]);
    check("u1_b_perr", u1_b_perr, qb2[16]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_a(input logic [3:0] ad, input logic [1:0] be, input logic [15:0] d);
    @(negedge clock);
    a_ce = 1; a_we = 1; a_a = ad; a_be = be; a_d = d;
    @(negedge clock);
    a_ce = 0; a_we = 0;
  endtask

  task automatic rd_a(input logic [3:0] ad, input logic [15:0] exp, input logic expp,
                      input string nm);
    @(negedge clock);
    a_ce = 1; a_we = 0; a_a = ad;
    @(posedge clock); #2;
    check({nm, "_u0_q"}, u0_a_q, exp);
    check({nm, "_u0_perr"}, u0_a_perr, expp);
    @(negedge clock);
    a_ce = 0;
    @(posedge clock); #2;
    check({nm, "_u1_q"}, u1_a_q, exp);
    check({nm, "_u1_perr"}, u1_a_perr, expp);
  endtask

  task automatic rd_b(input logic [3:0] ad, input logic [15:0] exp, input string nm);
    @(negedge clock);
    b_ce = 1; b_a = ad;
    @(posedge clock); #2;
    check({nm, "_u0"}, u0_b_q, exp);
    @(negedge clock);
    b_ce = 0;
    @(posedge clock); #2;
    check({nm, "_u1"}, u1_b_q, exp);
  endtask

  // Counts consecutive busy samples from the next edge on, bounded
  task automatic count_busy(input string nm, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #2;
      if (u0_busy) n++;
      else if (n > 0) break;
    end
    check({nm, "_busy_cycles"}, n, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset state
    repeat (3) @(negedge clock);
    check("rst_u0_a_q", u0_a_q, 16'h0);
    check("rst_u0_b_q", u0_b_q, 16'h0);
    check("rst_u1_a_q", u1_a_q, 16'h0);
    check("rst_busy",   u0_busy, 1'b0);
    check("rst_perr",   u0_a_perr, 1'b0);

    // automatic clear after reset: 16 busy cycles, all words INIT
    reset_n = 1;
    count_busy("init_clr", 16);
    for (int i = 0; i < DEPTH; i++) rd_b(4'(i), 16'hA5A5, "init_val");

    // byte enables
    wr_a(4'd3, 2'b11, 16'hFFFF);
    wr_a(4'd3, 2'b01, 16'h1234);
    rd_a(4'd3, 16'hFF34, 1'b0, "be_lo");
    wr_a(4'd3, 2'b10, 16'hABCD);
    rd_a(4'd3, 16'hAB34, 1'b0, "be_hi");

    // same-address collision: B sees the old word, then the new one
    wr_a(4'd7, 2'b11, 16'h0011);
    @(negedge clock);
    a_ce = 1; a_we = 1; a_a = 4'd7; a_be = 2'b11; a_d = 16'h0055;
    b_ce = 1; b_a = 4'd7;
    @(posedge clock); #2;
    check("coll_old_u0", u0_b_q, 16'h0011);
    @(negedge clock);
    a_ce = 0; a_we = 0;
    @(posedge clock); #2;
    check("coll_old_u1", u1_b_q, 16'h0011);
    check("coll_new_u0", u0_b_q, 16'h0055);
    @(negedge clock);
    b_ce = 0;
    @(posedge clock); #2;
    check("coll_new_u1", u1_b_q, 16'h0055);

    // two-cycle latency and hold
    wr_a(4'd2, 2'b11, 16'h003C);
    @(negedge clock);
    a_ce = 1; a_we = 0; a_a = 4'd2;
    @(posedge clock); #2;
    check("oreg_edge1", u1_a_q, 16'hAB34);
    @(negedge clock);
    a_ce = 0;
    @(posedge clock); #2;
    check("oreg_edge2", u1_a_q, 16'h003C);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      check("oreg_hold", u1_a_q, 16'h003C);
    end

    // clr restart at cnt=5; port A ignored while busy
    @(negedge clock); clr = 1;
    @(negedge clock); clr = 0;
    repeat (5) @(negedge clock);
    clr = 1;
    begin
      int n;
      n = 0;
      @(posedge clock); #2;
      if (u0_busy) n++;
      for (int i = 0; i < 60; i++) begin
        @(negedge clock);
        clr = 0;
        a_ce = 0; a_we = 0;
        if (i == 8) begin a_ce = 1; a_we = 1; a_a = 4'd0; a_be = 2'b11; a_d = 16'hDEAD; end
        if (i == 9) begin a_ce = 1; a_we = 0; a_a = 4'd0; end
        @(posedge clock); #2;
        if (i == 10) begin
          check("busy_hold_u0", u0_a_q, 16'h003C);
          check("busy_hold_u1", u1_a_q, 16'h003C);
        end
        if (u0_busy) n++;
        else break;
      end
      check("restart_busy_cycles", n, 16);
    end
    @(negedge clock); a_ce = 0; a_we = 0;
    rd_a(4'd0, 16'hA5A5, 1'b0, "busy_wr_dropped");

    // reset in the middle of a clear aborts it, then restarts
    @(negedge clock); clr = 1;
    @(negedge clock); clr = 0;
    repeat (4) @(negedge clock);
    reset_n = 0;
    #1;
    check("abort_busy", u0_busy, 1'b0);
    check("abort_a_q", u0_a_q, 16'h0);
    @(negedge clock);
    reset_n = 1;
    count_busy("abort_restart", 16);

    // parity: corrupted word flags, clean word does not
`ifdef RAM_PARITY_EN
    @(negedge clock);
    u0.mem[5] = u0.mem[5] ^ 16'h0001;
    u1.mem[5] = u1.mem[5] ^ 16'h0001;
    flip_addr = 4'd5;
    flip_cnt++;
    rd_a(4'd5, 16'hA5A4, 1'b1, "par_bad");
    rd_a(4'd6, 16'hA5A5, 1'b0, "par_clean");
`else
    rd_a(4'd5, 16'hA5A5, 1'b0, "par_off");
    rd_a(4'd6, 16'hA5A5, 1'b0, "par_off2");
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      a_ce = ($urandom_range(0, 3) != 0);
      a_we = 1'($urandom_range(0, 1));
      a_be = 2'($urandom);
      a_a  = 4'($urandom);
      a_d  = 16'($urandom);
      b_ce = 1'($urandom_range(0, 1));
      b_a  = ($urandom_range(0, 3) == 0) ? a_a : 4'($urandom);
      clr  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clock);
    a_ce = 0; a_we = 0; b_ce = 0; clr = 0;
    repeat (4) @(posedge clock);
    #3;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    nfail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog");
  end

endmodule
